// File: rtl/fx3_pkt_builder_if.sv
// Bus bundle between the packet builder and its neighbours. The upstream word
// stream (in_vld/in_data/in_rdy) and the loader-buffer write side
// (buffDataVld/buffData/buffXerReady/currentXferDone) travel together.
// The slave modport is the builder; the master modport is whatever drives the
// upstream words and models the loader.
interface fx3_pkt_builder_if;
  logic        in_vld;
  logic [31:0] in_data;
  logic        in_rdy;
  logic        buffDataVld;
  logic [31:0] buffData;
  logic        buffXerReady;
  logic        currentXferDone;

  modport master (
    output in_vld,
    output in_data,
    output currentXferDone,
    input  in_rdy,
    input  buffDataVld,
    input  buffData,
    input  buffXerReady
  );

  modport slave (
    input  in_vld,
    input  in_data,
    input  currentXferDone,
    output in_rdy,
    output buffDataVld,
    output buffData,
    output buffXerReady
  );
endinterface

// File: rtl/fx3_pkt_builder.sv
// FX3 packet builder: frames a 32-bit word stream into fixed-length packets
// (header, payload, checksum) and writes them into one loader buffer, then
// holds that buffer until the loader reports it drained. A stall timeout
// zero-pads a short payload so a partially filled buffer never waits forever.
module fx3_pkt_builder #(
  parameter int unsigned PKT_LOG2 = 8,
  parameter logic [7:0]  SRC_ID   = 8'h01,
  parameter int unsigned TIMEOUT  = 1024
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             frame_rst,
  fx3_pkt_builder_if.slave bus,
  output logic [15:0]      pkt_cnt,
  output logic [15:0]      pad_cnt
);

  // Packet sequencing states
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_HDR  = 3'd1;
  localparam logic [2:0] ST_PAY  = 3'd2;
  localparam logic [2:0] ST_SUM  = 3'd3;
  localparam logic [2:0] ST_RDY  = 3'd4;

  // Payload is N-2 words; the counter indexes them 0..N-3, so the final
  // payload word is seen when the counter equals N-3.
  localparam logic [PKT_LOG2-1:0] LAST_PAY  = PKT_LOG2'((1 << PKT_LOG2) - 3);
  localparam logic [15:0]         TIMEOUT_V = 16'(TIMEOUT);

  logic [2:0]          state_q,   state_d;
  logic [7:0]          seq_q,     seq_d;
  logic [31:0]         sum_q,     sum_d;
  logic [PKT_LOG2-1:0] pay_cnt_q, pay_cnt_d;
  logic [15:0]         stall_q,   stall_d;
  logic                padding_q, padding_d;
  logic                vld_q,     vld_d;
  logic [31:0]         data_q,    data_d;
  logic                xrdy_q,    xrdy_d;
  logic [15:0]         pkt_cnt_q, pkt_cnt_d;
  logic [15:0]         pad_cnt_q, pad_cnt_d;

  logic        in_rdy;
  logic        accept;
  logic        pay_step;
  logic [15:0] stall_inc;
  logic [31:0] header;

  // in_rdy depends only on registered state, so there is no path from
  // in_vld or currentXferDone through to in_rdy.
  assign in_rdy    = (state_q == ST_PAY) && !padding_q;
  assign accept    = bus.in_vld && in_rdy;
  // A payload slot is filled either by an accepted word or by a pad word.
  assign pay_step  = accept || padding_q;
  assign stall_inc = stall_q + 16'd1;
  assign header    = {16'hA55A, SRC_ID, seq_q};

  assign bus.in_rdy       = in_rdy;
  assign bus.buffDataVld  = vld_q;
  assign bus.buffData     = data_q;
  assign bus.buffXerReady = xrdy_q;
  assign pkt_cnt          = pkt_cnt_q;
  assign pad_cnt          = pad_cnt_q;

  // Next-state and write-port decode; frame_rst overrides everything last
  always_comb begin
    state_d   = state_q;
    seq_d     = seq_q;
    sum_d     = sum_q;
    pay_cnt_d = pay_cnt_q;
    stall_d   = stall_q;
    padding_d = padding_q;
    vld_d     = 1'b0;
    data_d    = data_q;
    xrdy_d    = xrdy_q;
    pkt_cnt_d = pkt_cnt_q;
    pad_cnt_d = pad_cnt_q;

    case (state_q)
      ST_IDLE: begin
        // The word that wakes us is left in place; it is taken in PAY.
        if (bus.in_vld) begin
          state_d = ST_HDR;
        end
      end

      ST_HDR: begin
        vld_d     = 1'b1;
        data_d    = header;
        sum_d     = header;
        pay_cnt_d = '0;
        stall_d   = '0;
        padding_d = 1'b0;
        state_d   = ST_PAY;
      end

      ST_PAY: begin
        if (padding_q) begin
          vld_d     = 1'b1;
          data_d    = 32'h0;
          pad_cnt_d = pad_cnt_q + 16'd1;
        end else if (accept) begin
          vld_d   = 1'b1;
          data_d  = bus.in_data;
          sum_d   = sum_q + bus.in_data;
          stall_d = '0;
        end else begin
          // Padding engages on the edge the stall count hits TIMEOUT, so
          // in_rdy is already low in the first padding cycle.
          stall_d = stall_inc;
          if (stall_inc == TIMEOUT_V) begin
            padding_d = 1'b1;
          end
        end

        if (pay_step) begin
          pay_cnt_d = pay_cnt_q + 1'b1;
          if (pay_cnt_q == LAST_PAY) begin
            padding_d = 1'b0;
            state_d   = ST_SUM;
          end
        end
      end

      ST_SUM: begin
        // Two's-complement of the running sum makes the packet total zero.
        vld_d   = 1'b1;
        data_d  = 32'h0 - sum_q;
        state_d = ST_RDY;
      end

      ST_RDY: begin
        // buffXerReady rises one cycle after the checksum write lands.
        if (bus.currentXferDone) begin
          xrdy_d    = 1'b0;
          seq_d     = seq_q + 8'd1;
          pkt_cnt_d = pkt_cnt_q + 16'd1;
          state_d   = ST_IDLE;
        end else begin
          xrdy_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (frame_rst) begin
      state_d   = ST_IDLE;
      seq_d     = '0;
      sum_d     = '0;
      pay_cnt_d = '0;
      stall_d   = '0;
      padding_d = 1'b0;
      vld_d     = 1'b0;
      data_d    = data_q;
      xrdy_d    = 1'b0;
      pkt_cnt_d = pkt_cnt_q;
      pad_cnt_d = pad_cnt_q;
    end
  end

  // State and output registers, cleared by the asynchronous reset
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= ST_IDLE;
      seq_q     <= '0;
      sum_q     <= '0;
      pay_cnt_q <= '0;
      stall_q   <= '0;
      padding_q <= 1'b0;
      vld_q     <= 1'b0;
      data_q    <= '0;
      xrdy_q    <= 1'b0;
      pkt_cnt_q <= '0;
      pad_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      seq_q     <= seq_d;
      sum_q     <= sum_d;
      pay_cnt_q <= pay_cnt_d;
      stall_q   <= stall_d;
      padding_q <= padding_d;
      vld_q     <= vld_d;
      data_q    <= data_d;
      xrdy_q    <= xrdy_d;
      pkt_cnt_q <= pkt_cnt_d;
      pad_cnt_q <= pad_cnt_d;
    end
  end

endmodule

// File: tb/tb_fx3_pkt_builder.sv
// Bench for fx3_pkt_builder with 8-word packets and a 4-cycle stall timeout.
// A word-position model predicts every output each cycle; literal values pin
// the first packet, the padded packet, and the abort/reset headers.
module tb_fx3_pkt_builder;
  localparam int         PKT_LOG2 = 3;
  localparam int         N        = 1 << PKT_LOG2;
  localparam int         TIMEOUT  = 4;
  localparam logic [7:0] SRC_ID   = 8'h01;

  logic        sys_clk;
  logic        sys_rst_n;
  logic        frame_rst;
  logic [15:0] pkt_cnt;
  logic [15:0] pad_cnt;

  fx3_pkt_builder_if bus();

  fx3_pkt_builder #(
    .PKT_LOG2(PKT_LOG2),
    .SRC_ID  (SRC_ID),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .frame_rst(frame_rst),
    .bus      (bus),
    .pkt_cnt  (pkt_cnt),
    .pad_cnt  (pad_cnt)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int vectors = 0;
  int fails   = 0;

  logic [31:0] wlog[$];

  // model: words already written into the current buffer (0..N)
  bit          m_started;
  int          m_written;
  int          m_idle;
  bit          m_pad;
  logic [7:0]  m_seq;
  logic [31:0] m_sum;
  logic [15:0] m_pkts;
  logic [15:0] m_pads;
  bit          e_vld;
  logic [31:0] e_data;
  bit          e_xrdy;
  int          pk_n;
  logic [31:0] pk_sum;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_log(input string nm, input int idx, input logic [31:0] exp);
    if (idx >= wlog.size()) begin
      vectors++;
      fails++;
      $display("FAIL %s: write #%0d never happened, required %h", nm, idx, exp);
    end else begin
      chk(nm, wlog[idx], exp);
    end
  endtask

  function automatic bit m_rdy();
    return m_started && (m_written >= 1) && (m_written <= N - 2) && !m_pad;
  endfunction

  task automatic model_reset();
    m_started = 0; m_written = 0; m_idle = 0; m_pad = 0;
    m_seq = 8'h0; m_sum = 32'h0; m_pkts = 16'h0; m_pads = 16'h0;
    e_vld = 0; e_data = 32'h0; e_xrdy = 0;
    pk_n = 0; pk_sum = 32'h0;
  endtask

  // Predict the outputs that follow the next rising edge from current inputs
  task automatic model_step();
    bit acc;
    acc   = bus.in_vld && m_rdy();
    e_vld = 0;
    if (frame_rst) begin
      m_started = 0; m_written = 0; m_idle = 0; m_pad = 0;
      m_seq = 8'h0; m_sum = 32'h0; e_xrdy = 0;
      pk_n = 0; pk_sum = 32'h0;
    end else if (!m_started) begin
      if (bus.in_vld) m_started = 1;
    end else if (m_written == 0) begin
      e_vld = 1; e_data = {16'hA55A, SRC_ID, m_seq};
      m_sum = e_data; m_written = 1; m_idle = 0; m_pad = 0;
    end else if (m_written <= N - 2) begin
      if (m_pad) begin
        e_vld = 1; e_data = 32'h0; m_pads++; m_written++;
      end else if (acc) begin
        e_vld = 1; e_data = bus.in_data; m_sum += bus.in_data;
        m_written++; m_idle = 0;
      end else begin
        m_idle++;
        if (m_idle == TIMEOUT) m_pad = 1;
      end
    end else if (m_written == N - 1) begin
      e_vld = 1; e_data = -m_sum; m_written = N;
    end else begin
      if (bus.currentXferDone) begin
        e_xrdy = 0; m_started = 0; m_written = 0; m_seq++; m_pkts++;
      end else begin
        e_xrdy = 1;
      end
    end
  endtask

  // Compare every cycle on the falling edge, log writes, then advance model
  always @(negedge sys_clk) begin
    if (!sys_rst_n) model_reset();
    chk("in_rdy",       bus.in_rdy,       m_rdy());
    chk("buffDataVld",  bus.buffDataVld,  e_vld);
    if (e_vld) chk("buffData", bus.buffData, e_data);
    chk("buffXerReady", bus.buffXerReady, e_xrdy);
    chk("pkt_cnt",      pkt_cnt,          m_pkts);
    chk("pad_cnt",      pad_cnt,          m_pads);
    if (bus.buffDataVld === 1'b1) begin
      wlog.push_back(bus.buffData);
      pk_sum += bus.buffData;
      pk_n++;
      if (pk_n == N) begin
        chk("pkt_sum", pk_sum, 32'h0);
        $display("packet written: %0d words, header %h, total %h", N, wlog[wlog.size() - N], pk_sum);
        pk_n = 0;
        pk_sum = 32'h0;
      end
    end
    if (sys_rst_n) model_step();
  end

  // Drive one cycle of inputs; acc reports whether the word is taken this cycle
  task automatic tick(input bit v, input logic [31:0] d, input bit done, input bit fr, output bit acc);
    bus.in_vld = v;
    bus.in_data = d;
    bus.currentXferDone = done;
    frame_rst = fr;
    acc = v && (bus.in_rdy === 1'b1);
    @(posedge sys_clk);
    #2;
  endtask

  task automatic idle(input int n);
    bit a;
    repeat (n) tick(0, 32'h0, 0, 0, a);
  endtask

  task automatic send(input int n, input int maxgap, input logic [31:0] base, input bit rnd);
    for (int k = 0; k < n; k++) begin
      logic [31:0] w;
      int          gap;
      int          guard;
      bit          acc;
      w     = rnd ? $urandom : base + k;
      gap   = (maxgap > 0 && k > 0) ? int'($urandom_range(0, maxgap)) : 0;
      guard = 0;
      acc   = 0;
      idle(gap);
      while (!acc && guard < 50) begin
        tick(1, w, 0, 0, acc);
        guard++;
      end
      if (!acc) begin
        vectors++;
        fails++;
        $display("FAIL send_accept: word %0d not taken after %0d cycles, required acceptance", k, guard);
        return;
      end
    end
  endtask

  task automatic wait_xrdy();
    bit seen;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.buffXerReady === 1'b1) begin
        seen = 1;
        break;
      end
      idle(1);
    end
    vectors++;
    if (!seen) begin
      fails++;
      $display("FAIL wait_xrdy: buffXerReady got 0 for 40 cycles, required 1");
    end
  endtask

  task automatic done_pulse(input bit fr);
    bit a;
    tick(0, 32'h0, 1, fr, a);
    idle(1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time got %0t, required completion", $time);
    $fatal(1, "bench timed out");
  end

  initial begin
    logic [31:0] exp1 [N];
    int p;
    int wn;
    int bad;
    bit a;
    exp1 = '{32'hA55A0100, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h5AA5FEEB};

    sys_rst_n = 0; frame_rst = 0;
    bus.in_vld = 0; bus.in_data = 0; bus.currentXferDone = 0;
    repeat (3) @(posedge sys_clk);
    #2;
    chk("rst_in_rdy", bus.in_rdy, 0);
    chk("rst_vld", bus.buffDataVld, 0);
    chk("rst_data", bus.buffData, 0);
    chk("rst_xrdy", bus.buffXerReady, 0);
    chk("rst_pkt_cnt", pkt_cnt, 0);
    chk("rst_pad_cnt", pad_cnt, 0);
    sys_rst_n = 1;
    idle(2);

    // basic packet, payload 1..6 back to back
    p = wlog.size();
    send(N - 2, 0, 32'h1, 0);
    wait_xrdy();
    for (int i = 0; i < N; i++) chk_log("basic_word", p + i, exp1[i]);
    done_pulse(0);
    chk("basic_pkt_cnt", pkt_cnt, 16'd1);

    // second packet, then hold the buffer with upstream pressing
    p = wlog.size();
    send(N - 2, 0, 32'h100, 0);
    wait_xrdy();
    chk_log("hold_header", p, 32'hA55A0101);
    wn = wlog.size();
    bad = 0;
    for (int i = 0; i < 500; i++) begin
      tick(1, 32'hDEAD0000 + i, 0, 0, a);
      if (a || bus.buffXerReady !== 1'b1) bad++;
    end
    chk("hold_violations", bad, 0);
    chk("hold_writes", wlog.size() - wn, 0);
    done_pulse(0);

    // stall timeout: two words then silence
    p = wlog.size();
    send(2, 0, 32'h10, 0);
    wait_xrdy();
    chk_log("pad_header", p, 32'hA55A0102);
    for (int i = 3; i < N - 1; i++) chk_log("pad_zero", p + i, 32'h0);
    chk_log("pad_checksum", p + N - 1, 32'h5AA5FEDD);
    chk("pad_cnt_after_timeout", pad_cnt, 16'd4);
    done_pulse(0);

    // random gaps below the timeout
    for (int r = 0; r < 3; r++) begin
      send(N - 2, TIMEOUT - 1, 32'h0, 1);
      wait_xrdy();
      done_pulse(0);
    end
    chk("random_no_pad", pad_cnt, 16'd4);
    chk("random_pkt_cnt", pkt_cnt, 16'd6);

    // abort mid-payload
    send(2, 0, 32'h200, 0);
    tick(0, 32'h0, 0, 1, a);
    chk("abort_pay_xrdy", bus.buffXerReady, 0);
    chk("abort_pay_in_rdy", bus.in_rdy, 0);
    chk("abort_pay_pkt_cnt", pkt_cnt, 16'd6);
    idle(2);
    p = wlog.size();
    send(N - 2, 0, 32'h300, 0);
    wait_xrdy();
    chk_log("abort_seq_header", p, 32'hA55A0100);
    // abort in RDY together with the loader's done pulse
    tick(0, 32'h0, 1, 1, a);
    chk("abort_rdy_xrdy", bus.buffXerReady, 0);
    chk("abort_rdy_pkt_cnt", pkt_cnt, 16'd6);
    idle(3);
    chk("abort_rdy_idle", bus.in_rdy, 0);
    p = wlog.size();
    send(N - 2, 0, 32'h310, 0);
    wait_xrdy();
    chk_log("abort2_header", p, 32'hA55A0100);
    done_pulse(0);
    chk("abort2_pkt_cnt", pkt_cnt, 16'd7);

    // asynchronous reset mid-packet
    send(3, 0, 32'h400, 0);
    bus.in_vld = 0;
    sys_rst_n = 0;
    #1;
    chk("arst_in_rdy", bus.in_rdy, 0);
    chk("arst_vld", bus.buffDataVld, 0);
    chk("arst_data", bus.buffData, 0);
    chk("arst_xrdy", bus.buffXerReady, 0);
    chk("arst_pkt_cnt", pkt_cnt, 0);
    chk("arst_pad_cnt", pad_cnt, 0);
    @(posedge sys_clk);
    #2;
    sys_rst_n = 1;
    idle(2);
    p = wlog.size();
    send(N - 2, 0, 32'h500, 0);
    wait_xrdy();
    chk_log("arst_header", p, 32'hA55A0100);
    done_pulse(0);
    chk("arst_pkt_cnt_after", pkt_cnt, 16'd1);

    idle(3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/fx3_pkt_builder.md
# fx3_pkt_builder

Packetizing stage directly upstream of the FX3 slave-FIFO interface's buffer write port. It accepts a stream of 32-bit status/telemetry words and frames them into fixed-length packets: header, payload, then checksum. It writes each packet into one loader buffer over `buffDataVld`/`buffData` and raises `buffXerReady`. It holds that buffer until the loader returns `currentXferDone`. A stall timeout zero-pads short packets so the host never waits indefinitely on a partially filled buffer.

## Interface
Parameters:
- `PKT_LOG2`, default 8: packet length is 2^PKT_LOG2 words, including header and checksum. Legal range 3..15, matching the loader `BUF_DEPTH` for this buffer.
- `SRC_ID`, default 8'h01: source identifier placed in the header.
- `TIMEOUT`, default 1024: number of idle cycles in PAY before zero-padding starts. Legal range 1..65535.

Ports:
- `sys_clk` in 1: the block's only clock.
- `sys_rst_n` in 1: asynchronous, active-low reset.
- `frame_rst` in 1: synchronous single-cycle abort/clear.
- `in_vld` in 1: upstream word valid.
- `in_data` in 32: upstream word.
- `in_rdy` out 1: upstream word accepted when `in_vld & in_rdy`.
- `buffDataVld` out 1: write strobe into the loader buffer.
- `buffData` out 32: write data into the loader buffer.
- `buffXerReady` out 1: buffer full and ready for bulk-in.
- `currentXferDone` in 1: single-cycle pulse from the loader; the buffer has been drained.
- `pkt_cnt` out 16: number of completed packets. Wraps.
- `pad_cnt` out 16: number of zero words inserted. Wraps.

## Operation
- Constants: N = 2^PKT_LOG2 and P = N−2 (payload words per packet).
- States: IDLE, HDR, PAY, SUM, RDY.
  - IDLE: `in_rdy`=0. Go to HDR when `in_vld`=1. The word is not consumed.
  - HDR: emit header {16'hA55A, SRC_ID, seq[7:0]}. Set sum = header. Clear the payload counter. Go to PAY.
  - PAY: `in_rdy`=1 unless padding.
    - On each accept: emit `in_data`, add it to sum, increment the payload counter, and clear the stall counter.
    - Each cycle without an accept increments the stall counter. When the stall counter reaches TIMEOUT, set `padding`.
    - While `padding`: `in_rdy`=0 and emit 32'h0 each cycle (sum unchanged, `pad_cnt`++) until the payload is complete.
    - After payload word P−1, go to SUM.
  - SUM: emit checksum = (−sum) mod 2^32, so that header + payload + checksum ≡ 0 mod 2^32. Go to RDY.
  - RDY: `buffXerReady`=1, `in_rdy`=0. On `currentXferDone`: `buffXerReady`→0, `seq`++, `pkt_cnt`++, then go to IDLE.
- `currentXferDone` outside RDY is ignored.
- `frame_rst` in any state:
  - next state is IDLE; `seq`, sum, stall counter, payload counter and `padding` are cleared;
  - `buffXerReady` and `buffDataVld` go to 0 the next cycle.
  - `pkt_cnt` and `pad_cnt` hold.
  - `frame_rst` has priority over every simultaneous event, including `currentXferDone`.
- Sum arithmetic is 32-bit modulo with no carry retained.
- `seq` is 8 bits and wraps 255→0.

## Timing
- Reset (`sys_rst_n`=0): state IDLE. All outputs are 0: `in_rdy`, `buffDataVld`, `buffData`, `buffXerReady`, `pkt_cnt`, `pad_cnt`. `seq`=0.
- `in_rdy` is decoded from registered state only; there is no combinational path from `in_vld` or `currentXferDone`.
- `buffDataVld` and `buffData` are registered. A word accepted in cycle t appears on `buffData` in cycle t+1 with `buffDataVld`=1. The header appears the cycle after HDR is entered.
- Each packet is exactly N `buffDataVld` pulses, in order header, payload, checksum. This holds with or without input stalls.
- `buffXerReady` rises the cycle after the checksum write, never in the same cycle as any `buffDataVld`.
- Minimum cycles from the IDLE→HDR decision to `buffXerReady`: N+1.
- Padding begins the cycle after the stall counter equals TIMEOUT. Padding words are back-to-back, one per cycle.
- An input arriving on the same cycle that `padding` sets is not accepted, because `in_rdy` is already 0.

## Test plan
- Basic packet: PKT_LOG2=3, SRC_ID=8'h01, payload 1..6 continuous.
  - Required writes: A55A0100, 1, 2, 3, 4, 5, 6, 5AA5FEEB, then `buffXerReady`=1.
  - Pulse `currentXferDone`: `pkt_cnt`=1, and the next header is A55A0101.
- Backpressure hold: keep `currentXferDone`=0 for 500 cycles while `in_vld`=1.
  - Required: `in_rdy`=0, no writes, `buffXerReady` stays 1 throughout.
- Timeout padding: TIMEOUT=4, send 2 payload words, then `in_vld`=0.
  - Required: after 4 idle cycles, four 32'h0 writes on consecutive cycles, `pad_cnt`=4, and the checksum still brings the packet total to 0.
- Randomized `in_vld` gaps shorter than TIMEOUT: exactly N writes per packet, zero padding, and the modulo sum over each packet is 0.
- Abort: `frame_rst` mid-PAY and again in RDY together with `currentXferDone`.
  - Required: state returns to IDLE, `buffXerReady`=0, `pkt_cnt` unchanged, and the next header has seq=0.
- Async reset mid-packet: `sys_rst_n` low for 1 cycle.
  - Required: all outputs 0 immediately; the next packet restarts with header A55A0100.
